// File: rtl/oh_clockdiv_ctrl.sv
// Reconfiguration sequencer for oh_clockdiv: gates the divider, lets the divided
// clock quiesce, loads the new divcfg and then restores the requested enable.
module oh_clockdiv_ctrl #(
    parameter int DW      = 4,
    parameter int SETTLE  = 256,
    parameter int EN_RST  = 1,
    parameter int DIV_RST = 0
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          access_in,
    input  logic [DW-1:0] divcfg_in,
    input  logic          en_in,
    output logic          wait_out,
    output logic          en_out,
    output logic [DW-1:0] divcfg_out,
    output logic          done_out
);

    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, LOAD, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   cfg_q, cfg_d;
    logic            en_req_q, en_req_d;
    logic            en_out_q, en_out_d;
    logic [DW-1:0]   divcfg_q, divcfg_d;
    logic            done_q, done_d;
    logic            wait_q, wait_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg_q;
        en_req_d = en_req_q;
        en_out_d = en_out_q;
        divcfg_d = divcfg_q;
        done_d   = done_q;
        case (state_q)
            IDLE: begin
                if (access_in) begin
                    cfg_d    = divcfg_in;
                    en_req_d = en_in;
                    if (en_out_q) begin
                        state_d  = DRAIN;
                        en_out_d = 1'b0;
                        cnt_d    = CW'(SETTLE - 1);
                    end else begin
                        // divider already gated: nothing to drain
                        state_d  = LOAD;
                        divcfg_d = divcfg_in;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d  = LOAD;
                    divcfg_d = cfg_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD: begin
                state_d  = DONE;
                en_out_d = en_req_q;
                done_d   = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        wait_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cfg_q    <= '0;
            en_req_q <= 1'b0;
            en_out_q <= 1'(EN_RST);
            divcfg_q <= DW'(DIV_RST);
            done_q   <= 1'b0;
            wait_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cfg_q    <= cfg_d;
            en_req_q <= en_req_d;
            en_out_q <= en_out_d;
            divcfg_q <= divcfg_d;
            done_q   <= done_d;
            wait_q   <= wait_d;
        end
    end

    assign wait_out   = wait_q;
    assign en_out     = en_out_q;
    assign divcfg_out = divcfg_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_oh_clockdiv_ctrl.sv
// Scoreboard bench for oh_clockdiv_ctrl: each accepted request pushes its expected
// completion (cycle, divcfg, en); a monitor pops and compares on every done pulse.
module tb_oh_clockdiv_ctrl;

    localparam int DW     = 4;
    localparam int SETTLE = 8;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          access_in = 1'b0;
    logic [DW-1:0] divcfg_in = '0;
    logic          en_in = 1'b0;
    logic          wait_out, en_out, done_out;
    logic [DW-1:0] divcfg_out;

    oh_clockdiv_ctrl #(.DW(DW), .SETTLE(SETTLE), .EN_RST(1), .DIV_RST(0)) dut (
        .clk(clk), .nreset(nreset), .access_in(access_in), .divcfg_in(divcfg_in),
        .en_in(en_in), .wait_out(wait_out), .en_out(en_out),
        .divcfg_out(divcfg_out), .done_out(done_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [DW-1:0] div;
        logic        en;
    } exp_t;

    exp_t  sb_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    done_cnt = 0;
    logic  en_model = 1'b1;
    logic  prev_en = 1'b1;
    logic [DW-1:0] prev_div = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", tag, act, cyc);
        end
    endtask

    // Completion monitor and glitch-safety invariants
    always @(negedge clk) begin
        if (nreset) begin
            if (done_out) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_divcfg", int'(divcfg_out), int'(e.div));
                    chk("done_en", int'(en_out), int'(e.en));
                    chk("done_wait", int'(wait_out), 1);
                end
            end
            if (divcfg_out != prev_div) begin
                chk("div_chg_while_en", int'(prev_en), 0);
                chk("en_rise_with_div", int'(en_out), 0);
            end
        end
        prev_en  = en_out;
        prev_div = divcfg_out;
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Issue one request as soon as the block is free; returns accept cycle T.
    task automatic req(input logic [DW-1:0] div, input logic en, output int t);
        exp_t e;
        int   budget;
        budget = 0;
        @(negedge clk);
        while (wait_out && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (wait_out) chk("req_timeout", 1, 0);
        access_in = 1'b1;
        divcfg_in = div;
        en_in     = en;
        t         = cyc;
        e.cyc     = t + (en_model ? SETTLE + 2 : 2);
        e.div     = div;
        e.en      = en;
        sb_q.push_back(e);
        en_model  = en;
        @(negedge clk);
        access_in = 1'b0;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((sb_q.size() != 0 || wait_out) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (sb_q.size() != 0 || wait_out) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int t;
        int d0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_en", int'(en_out), 1);
        chk("rst_div", int'(divcfg_out), 0);
        chk("rst_wait", int'(wait_out), 0);
        chk("rst_done", int'(done_out), 0);
        nreset = 1'b1;
        repeat (2) @(negedge clk);

        // Update with drain, plus an ignored request while busy
        @(negedge clk);
        access_in = 1'b1; divcfg_in = 4'd3; en_in = 1'b1;
        t = cyc;
        sb_q.push_back('{t + SETTLE + 2, 4'd3, 1'b1});
        @(negedge clk);
        access_in = 1'b0;
        chk("t1_en_low", int'(en_out), 0);
        chk("t1_wait", int'(wait_out), 1);
        wait_cyc(t + 3);
        access_in = 1'b1; divcfg_in = 4'd5; en_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        access_in = 1'b0;
        wait_cyc(t + SETTLE);
        chk("drain_end_en", int'(en_out), 0);
        chk("drain_end_div", int'(divcfg_out), 0);
        wait_cyc(t + SETTLE + 1);
        chk("load_div", int'(divcfg_out), 3);
        chk("load_en", int'(en_out), 0);
        wait_cyc(t + SETTLE + 3);
        chk("idle_wait", int'(wait_out), 0);
        repeat (3) @(negedge clk);
        chk("busy_ignored_div", int'(divcfg_out), 3);
        chk("busy_one_done", done_cnt, 1);

        // Disable, then update without drain
        req(4'd9, 1'b0, t);
        wait_idle();
        chk("disabled_en", int'(en_out), 0);
        req(4'd2, 1'b1, t);
        chk("nodrain_div", int'(divcfg_out), 2);
        chk("nodrain_en", int'(en_out), 0);
        wait_idle();
        chk("nodrain_en_after", int'(en_out), 1);

        // Same config still runs full sequence, then back-to-back
        req(4'd2, 1'b1, t);
        req(4'd4, 1'b1, d0);
        chk("b2b_accept", d0, t + SETTLE + 3);
        wait_idle();

        // Reset mid-drain discards the request
        req(4'd6, 1'b1, t);
        wait_cyc(t + 4);
        d0 = done_cnt;
        nreset = 1'b0;
        #1;
        chk("mid_rst_en", int'(en_out), 1);
        chk("mid_rst_div", int'(divcfg_out), 0);
        chk("mid_rst_wait", int'(wait_out), 0);
        sb_q.delete();
        en_model = 1'b1;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (SETTLE + 6) @(negedge clk);
        chk("mid_rst_no_done", done_cnt, d0);
        chk("mid_rst_div_hold", int'(divcfg_out), 0);

        // Random sequence under the invariant monitor
        for (int i = 0; i < 10; i++) begin
            req(DW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), t);
        end
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
